// File: rtl/i2s_tx_param.sv
// I2S / left-justified stereo transmitter: free-running mclk and bclk dividers,
// a one-pair holding register with valid/ready intake, and per-frame serialisation.
`timescale 1ns/1ps

module i2s_tx_param #(
  parameter int W         = 16,
  parameter int SLOT_BITS = 32,
  parameter int MODE      = 0,
  parameter int MCLK_HALF = 2,
  parameter int BCLK_HALF = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_left,
  input  logic [W-1:0] in_right,
  input  logic         mono,
  output logic         mclk,
  output logic         bclk,
  output logic         lrclk,
  output logic         sdata,
  output logic         frame_start,
  output logic         underrun
);

  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int PW = BW - 1;
  localparam int MW = $clog2(MCLK_HALF + 1);
  localparam int CW = $clog2(BCLK_HALF + 1);

  localparam logic [MW-1:0] MCLK_LAST = MW'(MCLK_HALF - 1);
  localparam logic [CW-1:0] BCLK_LAST = CW'(BCLK_HALF - 1);
  localparam logic [BW-1:0] B_LAST    = '1;
  localparam logic [W-1:0]  LSB_ONE   = W'(1);

  logic [MW-1:0] mclk_cnt;
  logic [CW-1:0] bclk_cnt;
  logic [BW-1:0] b;
  logic [W-1:0]  tx_left, tx_right;
  logic [W-1:0]  hold_left, hold_right;
  logic          full;

  logic          bclk_fall, load, accept, full_next;
  logic [BW-1:0] b_next;
  logic [PW-1:0] p_next;
  logic          lr_next;
  logic [W-1:0]  left_next, right_next, word, mask;
  logic          bit_val;
  int            pos;

  assign bclk_fall  = bclk && (bclk_cnt == BCLK_LAST);
  assign b_next     = b + BW'(1);
  assign p_next     = b_next[PW-1:0];
  assign lr_next    = b_next[PW];
  assign load       = bclk_fall && (b == B_LAST);
  assign accept     = in_valid && in_ready;
  assign full_next  = accept || (full && !load);

  // The bit driven at a frame load already comes from the freshly loaded pair.
  assign left_next  = (load && full) ? hold_left  : tx_left;
  assign right_next = (load && full) ? hold_right : tx_right;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    word    = lr_next ? right_next : left_next;
    pos     = int'(p_next);
    mask    = '0;
    if (MODE == 1) begin
      if (pos < W) mask = LSB_ONE << (W - 1 - pos);
    end else begin
      if (pos >= 1 && pos <= W) mask = LSB_ONE << (W - pos);
    end
    bit_val = |(word & mask);
  end

  // NOTE: sample payload is qualified by full, so it needs no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_left  <= in_left;
      hold_right <= mono ? in_left : in_right;
    end
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mclk_cnt    <= '0;
      bclk_cnt    <= '0;
      mclk        <= 1'b0;
      bclk        <= 1'b0;
      b           <= '0;
      lrclk       <= 1'b0;
      sdata       <= 1'b0;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
      tx_left     <= '0;
      tx_right    <= '0;
      full        <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      if (mclk_cnt == MCLK_LAST) begin
        mclk_cnt <= '0;
        mclk     <= ~mclk;
      end else begin
        mclk_cnt <= mclk_cnt + MW'(1);
      end

      if (bclk_cnt == BCLK_LAST) begin
        bclk_cnt <= '0;
        bclk     <= ~bclk;
      end else begin
        bclk_cnt <= bclk_cnt + CW'(1);
      end

      frame_start <= 1'b0;
      underrun    <= 1'b0;
      if (bclk_fall) begin
        b     <= b_next;
        lrclk <= lr_next;
        sdata <= bit_val;
        if (load) begin
          frame_start <= 1'b1;
          // An empty buffer repeats the previous pair rather than sending silence.
          if (full) begin
            tx_left  <= hold_left;
            tx_right <= hold_right;
          end else begin
            underrun <= 1'b1;
          end
        end
      end

      full     <= full_next;
      in_ready <= !full_next;
    end
  end

endmodule

// File: tb/tb_i2s_tx_param.sv
// Directed bench for i2s_tx_param: an I2S and a left-justified instance share one
// stimulus stream; serial frames are captured at each bit and compared to constants.
`timescale 1ns/1ps

module tb_i2s_tx_param;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
    logic        m;
  } pair_t;

  localparam logic [63:0] LR_PATTERN = 64'h0000_0000_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst, in_valid, mono;
  logic [15:0] in_left, in_right;

  logic rdy0, mclk0, bclk0, lrclk0, sdata0, fs0, under0;
  logic rdy1, mclk1, bclk1, lrclk1, sdata1, fs1, under1;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  pair_t       pq[$];
  logic [15:0] mseq;
  logic [31:0] bseq;

  always #5 clk = ~clk;

  i2s_tx_param #(.W(16), .SLOT_BITS(32), .MODE(0), .MCLK_HALF(2), .BCLK_HALF(8)) u_i2s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_left(in_left), .in_right(in_right), .mono(mono),
    .mclk(mclk0), .bclk(bclk0), .lrclk(lrclk0), .sdata(sdata0),
    .frame_start(fs0), .underrun(under0)
  );

  i2s_tx_param #(.W(16), .SLOT_BITS(32), .MODE(1), .MCLK_HALF(2), .BCLK_HALF(8)) u_lj (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .in_left(in_left), .in_right(in_right), .mono(mono),
    .mclk(mclk1), .bclk(bclk1), .lrclk(lrclk1), .sdata(sdata1),
    .frame_start(fs1), .underrun(under1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick_rec();
    tick();
    if (cyc <= 16) mseq = {mseq[14:0], mclk0};
    bseq = {bseq[30:0], bclk0};
  endtask

  task automatic offer_next();
    pair_t p;
    if (pq.size() > 0) begin
      p        = pq.pop_front();
      in_left  = p.l;
      in_right = p.r;
      mono     = p.m;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  function automatic logic [63:0] exp_i2s(input logic [15:0] l, input logic [15:0] r);
    return {1'b0, l, 15'h0, 1'b0, r, 15'h0};
  endfunction

  function automatic logic [63:0] exp_lj(input logic [15:0] l, input logic [15:0] r);
    return {l, 16'h0, r, 16'h0};
  endfunction

  // Waits (bounded) for the first frame load after a reset release.
  task automatic wait_fs(input string tag, input logic exp_under);
    logic z;
    int   i;
    z = 1'b0;
    i = 0;
    while (!fs0 && i < 2000) begin
      z = z | sdata0 | sdata1;
      tick();
      i++;
    end
    check({tag, "_seen"},  64'({fs0, fs1}), 64'(2'b11));
    check({tag, "_cyc"},   64'(cyc), 64'(1024));
    check({tag, "_zeros"}, 64'(z), 64'(0));
    check({tag, "_under"}, 64'({under0, under1}), 64'({2{exp_under}}));
  endtask

  // Starts just after a frame load; runs to (and includes) the next load.
  task automatic run_frame(input int offer_t, output logic [63:0] s0, output logic [63:0] s1,
                           output logic [63:0] lr, output int n_acc, output int n_under,
                           output int n_fs);
    logic acc;
    s0 = '0; s1 = '0; lr = '0;
    n_acc = 0; n_under = 0; n_fs = 0;
    for (int t = 0; t < 1024; t++) begin
      if (t == offer_t) offer_next();
      if (t % 16 == 0) begin
        s0 = {s0[62:0], sdata0};
        s1 = {s1[62:0], sdata1};
        lr = {lr[62:0], lrclk0};
      end
      acc = in_valid && rdy0;
      tick();
      if (acc) begin
        n_acc++;
        check("ready_after_accept", 64'({rdy0, rdy1}), 64'(0));
        offer_next();
      end
      if (under0) n_under++;
      if (under1) n_under++;
      if (fs0)    n_fs++;
    end
  endtask

  task automatic frame_check(input string tag, input int offer_t, input logic [63:0] e0,
                             input logic [63:0] e1, input int e_acc, input int e_under,
                             input logic e_rdy);
    logic [63:0] s0, s1, lr;
    int          n_acc, n_under, n_fs;
    run_frame(offer_t, s0, s1, lr, n_acc, n_under, n_fs);
    check({tag, "_i2s_data"}, s0, e0);
    check({tag, "_lj_data"},  s1, e1);
    check({tag, "_lrclk"},    lr, LR_PATTERN);
    check({tag, "_accepts"},  64'(n_acc), 64'(e_acc));
    check({tag, "_underrun"}, 64'(n_under), 64'(e_under));
    check({tag, "_fs_count"}, 64'(n_fs), 64'(1));
    check({tag, "_fs_end"},   64'({fs0, fs1}), 64'(2'b11));
    check({tag, "_ready"},    64'({rdy0, rdy1}), 64'({2{e_rdy}}));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_left = '0; in_right = '0; mono = 1'b0;
    mseq = '0; bseq = '0;
    repeat (3) tick();
    check("rst_out_i2s", 64'({mclk0, bclk0, lrclk0, sdata0, fs0, under0, rdy0}), 64'(0));
    check("rst_out_lj",  64'({mclk1, bclk1, lrclk1, sdata1, fs1, under1, rdy1}), 64'(0));
    rst = 1'b0;
    cyc = 0;

    tick_rec();
    check("ready_rise", 64'({rdy0, rdy1}), 64'(2'b11));
    in_valid = 1'b1; in_left = 16'hA5F0; in_right = 16'h0F5A;
    tick_rec();
    check("ready_drop_first", 64'({rdy0, rdy1}), 64'(0));
    // Held-off pair: must never reach the holding register.
    in_left = 16'h1234; in_right = 16'h5678;
    while (cyc < 32) tick_rec();
    in_valid = 1'b0;
    check("mclk_wave", 64'(mseq), 64'(16'h6666));
    check("bclk_wave", 64'(bseq), 64'(32'h01FE_01FE));

    wait_fs("first_load", 1'b0);
    frame_check("f1", -1, 64'h52F8_0000_07AD_0000, 64'hA5F0_0000_0F5A_0000, 0, 2, 1'b1);

    pq.push_back('{16'h3C3C, 16'hC3C3, 1'b0});
    pq.push_back('{16'h0001, 16'h8000, 1'b0});
    pq.push_back('{16'hFFFF, 16'h7FFE, 1'b0});
    // First new pair lands on the load cycle itself: that load still underruns.
    frame_check("f2", 1023, 64'h52F8_0000_07AD_0000, 64'hA5F0_0000_0F5A_0000, 1, 2, 1'b0);
    frame_check("f3", -1,   64'h52F8_0000_07AD_0000, 64'hA5F0_0000_0F5A_0000, 0, 0, 1'b1);
    frame_check("f4", -1, exp_i2s(16'h3C3C, 16'hC3C3), exp_lj(16'h3C3C, 16'hC3C3), 1, 0, 1'b1);
    frame_check("f5", -1, exp_i2s(16'h0001, 16'h8000), exp_lj(16'h0001, 16'h8000), 1, 0, 1'b1);
    frame_check("f6", -1, exp_i2s(16'hFFFF, 16'h7FFE), exp_lj(16'hFFFF, 16'h7FFE), 0, 2, 1'b1);

    pq.push_back('{16'h8001, 16'h7FFF, 1'b1});
    frame_check("f7", 0, exp_i2s(16'hFFFF, 16'h7FFE), exp_lj(16'hFFFF, 16'h7FFE), 1, 0, 1'b1);
    frame_check("f8_mono", -1, 64'h4000_8000_4000_8000, 64'h8001_0000_8001_0000, 0, 2, 1'b1);

    pq.push_back('{16'h1357, 16'h2468, 1'b0});
    mono = 1'b0;
    offer_next();
    tick();
    check("rst_test_accept", 64'({rdy0, rdy1}), 64'(0));
    in_valid = 1'b0;
    repeat (639) tick();
    check("b40_lrclk", 64'({lrclk0, lrclk1}), 64'(2'b11));
    rst = 1'b1;
    tick();
    check("midrst_out_i2s", 64'({mclk0, bclk0, lrclk0, sdata0, fs0, under0, rdy0}), 64'(0));
    check("midrst_out_lj",  64'({mclk1, bclk1, lrclk1, sdata1, fs1, under1, rdy1}), 64'(0));
    rst = 1'b0;
    cyc = 0;
    tick();
    check("midrst_ready", 64'({rdy0, rdy1}), 64'(2'b11));
    wait_fs("post_rst_load", 1'b1);
    frame_check("post_rst", -1, 64'h0, 64'h0, 0, 2, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_param.md
I2S_TX_PARAM -- requirements
Module: i2s_tx_param

Interface
REQ-001 The block SHALL have parameter W, default 16: sample width in bits, range 8..32.
REQ-002 The block SHALL have parameter SLOT_BITS, default 32: bclk periods per channel slot, power of 2, >= W (>= W+1 when MODE=0).
REQ-003 The block SHALL have parameter MODE, default 0: 0 = I2S (one-bit data delay), 1 = left-justified.
REQ-004 The block SHALL have parameter MCLK_HALF, default 2: clk cycles per mclk half-period, >= 1.
REQ-005 The block SHALL have parameter BCLK_HALF, default 8: clk cycles per bclk half-period, >= 1.
REQ-006 The block SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: a stereo sample pair is offered.
REQ-009 The block SHALL have port in_ready, output, 1 bit: the holding register is empty.
REQ-010 The block SHALL have port in_left, input, W bits: left sample, two's complement.
REQ-011 The block SHALL have port in_right, input, W bits: right sample, two's complement.
REQ-012 The block SHALL have port mono, input, 1 bit: when 1, in_left is captured into both channels and in_right is ignored.
REQ-013 The block SHALL have port mclk, output, 1 bit: codec master clock.
REQ-014 The block SHALL have port bclk, output, 1 bit: bit clock.
REQ-015 The block SHALL have port lrclk, output, 1 bit: word select; 0 = left slot, 1 = right slot.
REQ-016 The block SHALL have port sdata, output, 1 bit: serial data, MSB first.
REQ-017 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at each frame load.
REQ-018 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a frame load finds the holding register empty.

Function
REQ-019 mclk SHALL toggle every MCLK_HALF clk cycles from a free-running counter, independent of bclk.
REQ-020 bclk SHALL toggle every BCLK_HALF clk cycles; a falling edge is the cycle in which bclk is registered 1->0.
REQ-021 A bit counter b (0..2*SLOT_BITS-1) SHALL advance by one on each bclk falling edge and wrap from 2*SLOT_BITS-1 to 0.
REQ-022 lrclk, sdata, frame_start and underrun SHALL update only on bclk falling-edge cycles; lrclk SHALL equal (b >= SLOT_BITS).
REQ-023 With slot position p = b mod SLOT_BITS and MODE=1, sdata SHALL be sample[W-1-p] for p < W, else 0.
REQ-024 With MODE=0, sdata SHALL be 0 at p = 0, sample[W-p] for 1 <= p <= W, and 0 otherwise.
REQ-025 The sample used SHALL be the left shift register while lrclk=0 and the right shift register while lrclk=1.
REQ-026 Handshake: a transfer SHALL occur in any cycle with in_valid=1 and in_ready=1; the pair (or in_left twice if mono=1) is written to the holding register, and in_ready SHALL be 0 from the next cycle.
REQ-027 Frame load: on the falling edge where b wraps to 0, if the holding register is full, both shift registers SHALL load from it, it SHALL be marked empty, and in_ready SHALL be 1 next cycle.
REQ-028 If the holding register is empty at a frame load, the shift registers SHALL keep the previous pair (repeat) and underrun SHALL pulse for 1 cycle.
REQ-029 frame_start SHALL pulse for 1 cycle at every frame load, whether or not underrun also pulses.
REQ-030 A transfer and a frame load in the same cycle cannot conflict (in_ready=0 when full); a transfer into an empty holding register on the load cycle SHALL NOT affect that load, which reports underrun.
REQ-031 Back-pressure: in_valid held high with in_ready=0 SHALL NOT alter the holding register.
REQ-032 Latency: an accepted pair SHALL appear on sdata starting at the first frame load after acceptance; at most 1 frame buffered plus 1 playing.

Reset
REQ-033 While rst=1 and on the first cycle after it is released, mclk, bclk, lrclk, sdata, frame_start, underrun and in_ready SHALL be 0; all counters, b and both shift registers SHALL be 0; the holding register SHALL be empty.
REQ-034 in_ready SHALL be 1 from the second cycle after rst deasserts.
REQ-035 After reset, the first frame SHALL transmit zeros; the first frame load occurs at the first wrap of b to 0.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately and discard any buffered pair.

Verification
REQ-037 Defaults (W=16, SLOT_BITS=32, BCLK_HALF=8, MCLK_HALF=2): mclk period 4 clk, bclk period 16 clk, lrclk period 1024 clk, 50% duty.
REQ-038 MODE=1: accept L=0xA5F0, R=0x0F5A during frame 0 -> frame 1 left slot bits 0..15 = 1010010111110000, bits 16..31 = 0; right slot = 0000111101011010.
REQ-039 MODE=0, same data -> each slot p=0 is 0, p=1..16 carry the MSB..LSB, p=17..31 are 0, and lrclk edges align with p=0.
REQ-040 No transfer after the first pair -> frames 2, 3 repeat 0xA5F0/0x0F5A; underrun pulses once per frame load; frame_start pulses every 1024 clk.
REQ-041 in_valid held high with a new pair each accept -> in_ready drops 1 cycle after each accept and rises 1 cycle after each frame load; no pair is lost or duplicated and underrun stays 0.
REQ-042 mono=1, in_left=0x8001, in_right=0x7FFF -> both slots carry 0x8001; rst pulsed at b=40 -> all outputs 0, buffer emptied, restart from b=0.
